instr_mem_loadable: RTL

Parametrised, runtime-loadable instruction memory for the single-cycle RV32 core. It replaces the hard-coded instruction ROM with a word array filled over a byte-serial programming port. The port is driven by a UART or debug bridge, and bytes are assembled little-endian into 32-bit words. The CPU read port stays combinational for single-cycle fetch. Words not written since the last programming session read back as NOP, and `cpu_stall` holds the core while a load is in progress.

---
 rtl/instr_mem_loadable.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: byte-serial programming port assembling
// little-endian words, combinational fetch port, unwritten words read as NOP.
module instr_mem_loadable #(
  parameter int unsigned           INS_ADDRESS = 9,
  parameter int unsigned           INS_W       = 32,
  parameter logic [INS_W-1:0]      NOP_INSTR   = 32'h00007033
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INS_ADDRESS-1:0]   ra,
  output logic [INS_W-1:0]         rd,
  input  logic                     prog_en,
  input  logic                     prog_valid,
  input  logic [7:0]               prog_byte,
  output logic                     prog_ready,
  output logic                     prog_done,
  output logic                     prog_ovf,
  output logic [INS_ADDRESS-2:0]   prog_words,
  output logic                     cpu_stall
);

  localparam int unsigned AW    = INS_ADDRESS - 2;
  localparam int unsigned PW    = INS_ADDRESS - 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [PW-1:0] WORDS_MAX = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t             state;
  logic [AW-1:0]      wr_ptr;
  logic [1:0]         byte_cnt;
  logic [23:0]        asm_word;
  logic [DEPTH-1:0]   vld;
  logic [INS_W-1:0]   mem [DEPTH];

  logic               accept;
  logic               wr_en;
  logic [INS_W-1:0]   wr_data;
  logic [AW-1:0]      rd_idx;
  logic               unused_ra_lsbs;

  assign unused_ra_lsbs = ^ra[1:0];
  assign rd_idx         = ra[INS_ADDRESS-1:2];
  assign prog_ready     = (state == LOAD) && prog_en;
  assign cpu_stall      = (state != IDLE);
  assign prog_done      = (state == DONE);

  // The 4th byte bypasses the assembly register and lands directly in memory.
  always_comb begin
    accept  = prog_ready && prog_valid;
    wr_en   = (accept && (byte_cnt == 2'd3)) || (state == FLUSH);
    wr_data = (state == FLUSH) ? {8'h00, asm_word} : {prog_byte, asm_word};
  end

  always_comb begin
    rd = vld[rd_idx] ? mem[rd_idx] : NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      vld        <= '0;
      prog_words <= '0;
      prog_ovf   <= 1'b0;
    end else begin
      if (wr_en) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
        if (prog_words != WORDS_MAX) prog_words <= prog_words + 1'b1;
        if (wr_ptr == '1) prog_ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (prog_en) begin
            state      <= LOAD;
            vld        <= '0;
            wr_ptr     <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            prog_words <= '0;
            prog_ovf   <= 1'b0;
          end
        end
        LOAD: begin
          if (!prog_en) begin
            state <= (byte_cnt != '0) ? FLUSH : DONE;
          end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            // Cleared on word completion so a later flush zero-fills upper bytes.
            case (byte_cnt)
              2'd0:    asm_word[7:0]   <= prog_byte;
              2'd1:    asm_word[15:8]  <= prog_byte;
              2'd2:    asm_word[23:16] <= prog_byte;
              default: asm_word        <= '0;
            endcase
          end
        end
        FLUSH: begin
          state    <= DONE;
          byte_cnt <= '0;
          asm_word <= '0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
